// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA output bundle of vga_frame_reader.
// master: the frame reader. slave: the BRAM/display side that feeds din and rgbmode.
interface vga_frame_reader_if #(
    parameter int unsigned c_nb_img_pxls = 19
);
    logic [2:0]               rgbmode;
    logic [c_nb_img_pxls-1:0] addr;
    logic [7:0]               din;
    logic                     hsync;
    logic                     vsync;
    logic [3:0]               vga_red;
    logic [3:0]               vga_green;
    logic [3:0]               vga_blue;
    logic                     visible;
    logic                     frame_start;

    modport master (
        input  rgbmode,
        input  din,
        output addr,
        output hsync,
        output vsync,
        output vga_red,
        output vga_green,
        output vga_blue,
        output visible,
        output frame_start
    );

    modport slave (
        output rgbmode,
        output din,
        input  addr,
        input  hsync,
        input  vsync,
        input  vga_red,
        input  vga_green,
        input  vga_blue,
        input  visible,
        input  frame_start
    );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA frame reader: generates 640x480@60 raster timing from a clk/c_clk_div pixel
// tick, streams raster-order frame-buffer addresses and maps each byte
// (RGB332 or gray) to 4:4:4 colour. All outputs trail the counters by one pixel.
// Optional: define VGA_FRAME_READER_BARS_EN to add a test_bars input that
// replaces the image with 8 vertical colour bars.
module vga_frame_reader #(
    parameter int unsigned c_img_cols    = 640,
    parameter int unsigned c_img_rows    = 480,
    parameter int unsigned c_nb_img_pxls = 19,
    parameter int unsigned c_clk_div     = 4,
    parameter int unsigned c_h_fp        = 16,
    parameter int unsigned c_h_sync      = 96,
    parameter int unsigned c_h_bp        = 48,
    parameter int unsigned c_v_fp        = 10,
    parameter int unsigned c_v_sync      = 2,
    parameter int unsigned c_v_bp        = 33
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VGA_FRAME_READER_BARS_EN
    input  logic               test_bars,
`endif
    vga_frame_reader_if.master vga
);

    localparam int unsigned c_h_total  = c_img_cols + c_h_fp + c_h_sync + c_h_bp;
    localparam int unsigned c_v_total  = c_img_rows + c_v_fp + c_v_sync + c_v_bp;
    localparam int unsigned c_h_w      = $clog2(c_h_total);
    localparam int unsigned c_v_w      = $clog2(c_v_total);
    localparam int unsigned c_div_w    = (c_clk_div > 1) ? $clog2(c_clk_div) : 1;
    localparam int unsigned c_hs_first = c_img_cols + c_h_fp;
    localparam int unsigned c_hs_last  = c_hs_first + c_h_sync - 1;
    localparam int unsigned c_vs_first = c_img_rows + c_v_fp;
    localparam int unsigned c_vs_last  = c_vs_first + c_v_sync - 1;

    logic [c_div_w-1:0]       cnt_div;
    logic [c_h_w-1:0]         h_cnt;
    logic [c_v_w-1:0]         v_cnt;
    logic [c_nb_img_pxls-1:0] addr_q;

    logic       tick_c;
    logic       h_last_c;
    logic       v_last_c;
    logic       act_c;
    logic       hs_c;
    logic       vs_c;
    logic [3:0] red_c;
    logic [3:0] green_c;
    logic [3:0] blue_c;

    assign tick_c   = (cnt_div == c_div_w'(c_clk_div - 1));
    assign h_last_c = (h_cnt == c_h_w'(c_h_total - 1));
    assign v_last_c = (v_cnt == c_v_w'(c_v_total - 1));
    assign act_c    = (h_cnt < c_h_w'(c_img_cols)) && (v_cnt < c_v_w'(c_img_rows));
    assign hs_c     = !((h_cnt >= c_h_w'(c_hs_first)) && (h_cnt <= c_h_w'(c_hs_last)));
    assign vs_c     = !((v_cnt >= c_v_w'(c_vs_first)) && (v_cnt <= c_v_w'(c_vs_last)));

    assign vga.addr = addr_q;

`ifdef VGA_FRAME_READER_BARS_EN
    localparam int unsigned c_bar_w = c_img_cols / 8;

    logic [2:0] bar_c;

    // Bar index = h / bar width, as a compare chain against constant bar edges.
    function automatic logic [2:0] bar_index(input logic [c_h_w-1:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(h) >= i * c_bar_w) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign bar_c = bar_index(h_cnt);
`endif

    // Pixel-tick divider: tick in the last clk of every pixel period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_div <= '0;
        end else if (tick_c) begin
            cnt_div <= '0;
        end else begin
            cnt_div <= cnt_div + c_div_w'(1);
        end
    end

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick_c) begin
            if (h_last_c) begin
                h_cnt <= '0;
                v_cnt <= v_last_c ? '0 : v_cnt + c_v_w'(1);
            end else begin
                h_cnt <= h_cnt + c_h_w'(1);
            end
        end
    end

    // Raster-order read address: advances on visible pixels only, restarts each frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else if (tick_c) begin
            if (h_last_c && v_last_c) begin
                addr_q <= '0;
            end else if (act_c) begin
                addr_q <= addr_q + c_nb_img_pxls'(1);
            end
        end
    end

    // Byte-to-colour mapping for the pixel currently held in the counters.
    always_comb begin
        red_c   = 4'd0;
        green_c = 4'd0;
        blue_c  = 4'd0;
        if (act_c) begin
            if (vga.rgbmode < 3'd3) begin
                red_c   = {vga.din[7:5], vga.din[7]};
                green_c = {vga.din[4:2], vga.din[4]};
                blue_c  = {vga.din[1:0], vga.din[1:0]};
            end else begin
                red_c   = vga.din[7:4];
                green_c = vga.din[7:4];
                blue_c  = vga.din[7:4];
            end
`ifdef VGA_FRAME_READER_BARS_EN
            if (test_bars) begin
                red_c   = {4{bar_c[2]}};
                green_c = {4{bar_c[1]}};
                blue_c  = {4{bar_c[0]}};
            end
`endif
        end
    end

    // Output registers: one pixel behind the counters so sync and data stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.visible     <= 1'b0;
            vga.vga_red     <= 4'd0;
            vga.vga_green   <= 4'd0;
            vga.vga_blue    <= 4'd0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.frame_start <= tick_c && h_last_c && v_last_c;
            if (tick_c) begin
                vga.hsync     <= hs_c;
                vga.vsync     <= vs_c;
                vga.visible   <= act_c;
                vga.vga_red   <= red_c;
                vga.vga_green <= green_c;
                vga.vga_blue  <= blue_c;
            end
        end
    end

endmodule
